sc_computer: RTL and testbench

SC_COMPUTER -- requirements
Module: sc_computer

---
 rtl/sc_computer.sv | 140 ++++++++++++++
 tb/tb_sc_computer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/sc_computer.sv
// sc_computer: 4-step single-cycle adder datapath with six 7-segment decimal displays.
// Latency: operands sampled at pc=0/pc=1 reach the displays at the edge that ends pc=3.
// Backpressure: none; free-running pc, displays refresh every 4 cycles.
// Optional macro SC_COMPUTER_HEX_BLANK_EN blanks tens digits that are zero.
module sc_computer #(
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] one,
  input  logic [3:0] two,
  output logic [6:0] hex5,
  output logic [6:0] hex4,
  output logic [6:0] hex3,
  output logic [6:0] hex2,
  output logic [6:0] hex1,
  output logic [6:0] hex0
);

  logic [1:0] pc_q, pc_d;
  logic [3:0] r1_q, r1_d;
  logic [3:0] r2_q, r2_d;
  logic [4:0] r3_q, r3_d;
  logic [3:0] d1_q, d1_d;
  logic [3:0] d2_q, d2_d;
  logic [4:0] d3_q, d3_d;

  // Active-low segment code for one decimal digit (bit0=a .. bit6=g).
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] c;
    case (d)
      4'd0:    c = 7'h40;
      4'd1:    c = 7'h79;
      4'd2:    c = 7'h24;
      4'd3:    c = 7'h30;
      4'd4:    c = 7'h19;
      4'd5:    c = 7'h12;
      4'd6:    c = 7'h02;
      4'd7:    c = 7'h78;
      4'd8:    c = 7'h00;
      4'd9:    c = 7'h10;
      default: c = 7'h7F;
    endcase
    return c;
  endfunction

  // Tens digit of a 0..30 value by range compare; cheaper than a divider.
  function automatic logic [1:0] tens_of(input logic [4:0] v);
    logic [1:0] t;
    if (v >= 5'd30)      t = 2'd3;
    else if (v >= 5'd20) t = 2'd2;
    else if (v >= 5'd10) t = 2'd1;
    else                 t = 2'd0;
    return t;
  endfunction

  // Units digit given the already-resolved tens digit.
  function automatic logic [3:0] units_of(input logic [4:0] v, input logic [1:0] t);
    logic [3:0] u;
    case (t)
      2'd0:    u = 4'(v);
      2'd1:    u = 4'(v - 5'd10);
      2'd2:    u = 4'(v - 5'd20);
      default: u = 4'(v - 5'd30);
    endcase
    return u;
  endfunction

  // Tens digit code, optionally blanked when zero.
  function automatic logic [6:0] tens_code(input logic [1:0] t);
`ifdef SC_COMPUTER_HEX_BLANK_EN
    return (t == 2'd0) ? 7'h7F : seg_code({2'b00, t});
`else
    return seg_code({2'b00, t});
`endif
  endfunction

  // Apply output polarity: codes are active-low internally.
  function automatic logic [6:0] polarity(input logic [6:0] c);
    return (SEG_ACTIVE_LOW != 0) ? c : ~c;
  endfunction

  // Program step selected by pc; every register holds except on its own step.
  always_comb begin
    pc_d = pc_q + 2'd1;
    r1_d = r1_q;
    r2_d = r2_q;
    r3_d = r3_q;
    d1_d = d1_q;
    d2_d = d2_q;
    d3_d = d3_q;
    case (pc_q)
      2'd0: r1_d = one;
      2'd1: r2_d = two;
      2'd2: r3_d = {1'b0, r1_q} + {1'b0, r2_q};
      default: begin
        d1_d = r1_q;
        d2_d = r2_q;
        d3_d = r3_q;
      end
    endcase
  end

  // State registers; reset clears everything asynchronously so the period restarts at pc=0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q <= 2'd0;
      r1_q <= 4'd0;
      r2_q <= 4'd0;
      r3_q <= 5'd0;
      d1_q <= 4'd0;
      d2_q <= 4'd0;
      d3_q <= 5'd0;
    end else begin
      pc_q <= pc_d;
      r1_q <= r1_d;
      r2_q <= r2_d;
      r3_q <= r3_d;
      d1_q <= d1_d;
      d2_q <= d2_d;
      d3_q <= d3_d;
    end
  end

  logic [1:0] t1, t2, t3;

  // Display decode from the D registers only, so operand switches never reach the hex pins directly.
  always_comb begin
    t1   = tens_of({1'b0, d1_q});
    t2   = tens_of({1'b0, d2_q});
    t3   = tens_of(d3_q);
    hex5 = polarity(tens_code(t1));
    hex4 = polarity(seg_code(units_of({1'b0, d1_q}, t1)));
    hex3 = polarity(tens_code(t2));
    hex2 = polarity(seg_code(units_of({1'b0, d2_q}, t2)));
    hex1 = polarity(tens_code(t3));
    hex0 = polarity(seg_code(units_of(d3_q, t3)));
  end

endmodule

// File: tb/tb_sc_computer.sv
// Bench for sc_computer: directed operand pairs, async reset, mid-period operand changes.
// A period-level model predicts the displayed (one, two, sum) triple; all six digits checked each negedge.
module tb_sc_computer;

  logic       clock;
  logic       reset;
  logic [3:0] one, two;
  logic [6:0] hex5, hex4, hex3, hex2, hex1, hex0;

  int checks   = 0;
  int failures = 0;
  bit run_cmp  = 0;

`ifdef SC_COMPUTER_HEX_BLANK_EN
  localparam logic [6:0] T0 = 7'h7F;
`else
  localparam logic [6:0] T0 = 7'h40;
`endif

  sc_computer #(.SEG_ACTIVE_LOW(1)) dut (
    .clock(clock), .reset(reset), .one(one), .two(two),
    .hex5(hex5), .hex4(hex4), .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Digit table straight from the segment code list.
  function automatic logic [6:0] digit(input int d);
    logic [6:0] tbl [10];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return tbl[d];
  endfunction

  function automatic logic [6:0] tens_exp(input int v);
`ifdef SC_COMPUTER_HEX_BLANK_EN
    if (v / 10 == 0) return 7'h7F;
`endif
    return digit(v / 10);
  endfunction

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%02h expected=0x%02h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Period model: count edges since reset; sampled operands become visible as a triple every 4th edge.
  int edge_cnt;
  int s1, s2;
  int m1, m2, m3;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      edge_cnt = 0; s1 = 0; s2 = 0; m1 = 0; m2 = 0; m3 = 0;
    end else begin
      if (edge_cnt % 4 == 0) s1 = int'(one);
      if (edge_cnt % 4 == 1) s2 = int'(two);
      if (edge_cnt % 4 == 3) begin
        m1 = s1; m2 = s2; m3 = s1 + s2;
      end
      edge_cnt++;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (run_cmp) begin
      chk("m_hex5", hex5, tens_exp(m1));
      chk("m_hex4", hex4, digit(m1 % 10));
      chk("m_hex3", hex3, tens_exp(m2));
      chk("m_hex2", hex2, digit(m2 % 10));
      chk("m_hex1", hex1, tens_exp(m3));
      chk("m_hex0", hex0, digit(m3 % 10));
    end
  end

  task automatic lit(input string tag, input logic [6:0] e5, input logic [6:0] e4,
                     input logic [6:0] e3, input logic [6:0] e2,
                     input logic [6:0] e1, input logic [6:0] e0);
    chk({tag, "_hex5"}, hex5, e5);
    chk({tag, "_hex4"}, hex4, e4);
    chk({tag, "_hex3"}, hex3, e3);
    chk({tag, "_hex2"}, hex2, e2);
    chk({tag, "_hex1"}, hex1, e1);
    chk({tag, "_hex0"}, hex0, e0);
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Drive inputs a few units after an edge so they are stable at the next one.
  task automatic drive(input int a, input int b);
    #2;
    one = 4'(a);
    two = 4'(b);
  endtask

  initial begin
    reset = 1'b1;
    one   = 4'd0;
    two   = 4'd0;
    #1;
    lit("rst_async", T0, 7'h40, T0, 7'h40, T0, 7'h40);
    run_cmp = 1;
    edges(2);

    // 3 + 4: displays hold through edges 1..3, update on edge 4.
    drive(3, 4);
    reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      edges(1);
      lit($sformatf("hold%0d", i), T0, 7'h40, T0, 7'h40, T0, 7'h40);
    end
    edges(1);
    lit("3p4", T0, 7'h30, T0, 7'h19, T0, 7'h78);

    // 15 + 15 = 30.
    drive(15, 15);
    edges(4);
    lit("15p15", 7'h79, 7'h12, 7'h79, 7'h12, 7'h30, 7'h40);

    // one changes after its sampling edge: 2 + 5 shown, 9 only next period.
    drive(2, 5);
    edges(1);
    drive(9, 5);
    edges(3);
    lit("late_one", T0, 7'h24, T0, 7'h12, T0, 7'h78);
    edges(4);
    lit("next_one", T0, 7'h10, T0, 7'h12, 7'h79, 7'h19);

    // A few more directed pairs checked by the model only.
    drive(0, 0);  edges(4);
    drive(9, 1);  edges(4);
    drive(10, 10); edges(4);
    drive(15, 0); edges(4);
    drive(7, 13); edges(4);

    // Reset during pc=2 with 15+15 on display.
    drive(15, 15);
    edges(4);
    lit("pre_rst", 7'h79, 7'h12, 7'h79, 7'h12, 7'h30, 7'h40);
    drive(6, 6);
    edges(2);
    #2;
    reset = 1'b1;
    #1;
    lit("rst_mid", T0, 7'h40, T0, 7'h40, T0, 7'h40);
    edges(1);
    drive(3, 4);
    reset = 1'b0;
    edges(3);
    lit("rst_wait", T0, 7'h40, T0, 7'h40, T0, 7'h40);
    edges(1);
    lit("rst_3p4", T0, 7'h30, T0, 7'h19, T0, 7'h78);

    edges(2);
    run_cmp = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
